// File: rtl/cordic_angle_sweeper.sv
// Angle sequencer for the CORDIC sin/cos engine: steps a 0..359 degree phase, runs the
// start/done handshake per angle and captures each result together with its angle.
module cordic_angle_sweeper #(
  parameter int unsigned TIMEOUT_CYCLES = 63,
  parameter int unsigned START_ANGLE    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [8:0]  step_deg,
  input  logic        clr_err,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic        cordic_done,
  input  logic [15:0] cordic_sin,
  input  logic [15:0] cordic_cos,
  output logic [8:0]  angle_out,
  output logic [15:0] sin_out,
  output logic [15:0] cos_out,
  output logic        out_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [7:0] TmoLimit   = 8'(TIMEOUT_CYCLES);
  localparam logic [8:0] StartPhase = 9'(START_ANGLE);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitClr,
    StWaitSet,
    StSettle,
    StCapture
  } state_e;

  state_e      state_q;
  logic [8:0]  phase_q;
  logic [7:0]  tmo_cnt_q;

  logic [8:0]  step_sub;
  logic [8:0]  step_eff;
  logic [9:0]  phase_sum;
  logic [9:0]  phase_wrap;
  logic [8:0]  phase_next;
  logic        tmo_hit;

  // Next phase after a capture; both operands are below 360 so one subtraction suffices.
  always_comb begin
    step_sub   = step_deg - 9'd360;
    step_eff   = (step_deg >= 9'd360) ? step_sub : step_deg;
    phase_sum  = {1'b0, phase_q} + {1'b0, step_eff};
    phase_wrap = phase_sum - 10'd360;
    phase_next = (phase_sum >= 10'd360) ? phase_wrap[8:0] : phase_sum[8:0];
    tmo_hit    = (tmo_cnt_q == TmoLimit);
  end

  assign cordic_angle = {7'd0, phase_q};
  assign busy         = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      phase_q      <= StartPhase;
      tmo_cnt_q    <= 8'd0;
      cordic_start <= 1'b0;
      angle_out    <= 9'd0;
      sin_out      <= 16'd0;
      cos_out      <= 16'd0;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cordic_start <= 1'b0;
      out_valid    <= 1'b0;
      if (clr_err) begin
        timeout_err <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q      <= StIssue;
            cordic_start <= 1'b1;
          end
        end
        StIssue: begin
          tmo_cnt_q <= 8'd0;
          state_q   <= StWaitClr;
        end
        // A done flag still high from the previous run must drop before we look for completion.
        StWaitClr: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (!cordic_done) begin
              state_q <= StWaitSet;
            end
          end
        end
        StWaitSet: begin
          if (tmo_hit) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
            if (cordic_done) begin
              state_q <= StSettle;
            end
          end
        end
        StSettle: begin
          state_q <= StCapture;
        end
        StCapture: begin
          sin_out   <= cordic_sin;
          cos_out   <= cordic_cos;
          angle_out <= phase_q;
          out_valid <= 1'b1;
          phase_q   <= phase_next;
          if (enable) begin
            state_q      <= StIssue;
            cordic_start <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
